// File: rtl/id_stage_pipe.sv
// RV32I decode stage: decode, register-file read and immediate build into a registered ID/EX boundary.
// Latency: 1 cycle from an accepted i_inst/i_pc to the o_* payload with o_valid=1.
// Backpressure: o_ready drops on flush, load-use hazard or a stalled full ID/EX; a stalled payload holds bit-exact.
// Optional macro ID_WB_BYPASS_EN: a same-cycle write-back is forwarded into the operand read.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [31:0]                 i_inst,
  input  logic [XLEN-1:0]             i_pc,
  input  logic                        i_flush,
  input  logic                        i_wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] i_wb_addr,
  input  logic [XLEN-1:0]             i_wb_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [XLEN-1:0]             o_pc,
  output logic [XLEN-1:0]             o_rs1_data,
  output logic [XLEN-1:0]             o_rs2_data,
  output logic [XLEN-1:0]             o_imm,
  output logic [$clog2(NUM_REGS)-1:0] o_rd,
  output logic [13:0]                 o_ctrl
);
  localparam int RA_W = $clog2(NUM_REGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // alu_src1: 1 selects pc; alu_src2: 1 selects imm.
  // alu_op: 00 add, 01 branch compare, 10 R funct, 11 I funct.
  // data_sel: 000 alu, 001 memory, 010 pc+4, 011 imm.
  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src1;
    logic       alu_src2;
    logic [1:0] alu_op;
    logic [2:0] data_sel;
    logic       illegal;
  } ctrl_t;

  ctrl_t            ctrl_dec, ctrl_d, ctrl_q;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_d, imm_q, pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q;
  logic [RA_W-1:0]  rd_d, rd_q, rs1, rs2, rd;
  logic             valid_d, valid_q;
  logic             use_rs1, use_rs2, use_rd, bad_idx, haz, ready;
  logic [6:0]       opcode;
  logic [XLEN-1:0]  rf_d [NUM_REGS];
  logic [XLEN-1:0]  rf_q [NUM_REGS];

  // A register field is out of range when it has bits set above RA_W.
  function automatic logic idx_hi(input logic [4:0] f);
    return (f >> RA_W) != 5'd0;
  endfunction

  assign opcode = i_inst[6:0];
  assign rs1    = i_inst[15 +: RA_W];
  assign rs2    = i_inst[20 +: RA_W];
  assign rd     = i_inst[7 +: RA_W];

  // Opcode decode: control bits, immediate format and which register fields are live.
  always_comb begin
    ctrl_dec = '0;
    imm32    = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.data_sel = 3'b011; use_rd = 1'b1;
        imm32 = {i_inst[31:12], 12'b0};
      end
      OP_AUIPC: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src1 = 1'b1; ctrl_dec.alu_src2 = 1'b1; use_rd = 1'b1;
        imm32 = {i_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        ctrl_dec.jal = 1'b1; ctrl_dec.reg_write = 1'b1; ctrl_dec.data_sel = 3'b010; use_rd = 1'b1;
        imm32 = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl_dec.jalr = 1'b1; ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src2 = 1'b1;
        ctrl_dec.data_sel = 3'b010; use_rs1 = 1'b1; use_rd = 1'b1;
        imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      OP_BRANCH: begin
        ctrl_dec.branch = 1'b1; ctrl_dec.alu_op = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      end
      OP_LOAD: begin
        ctrl_dec.mem_read = 1'b1; ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src2 = 1'b1;
        ctrl_dec.data_sel = 3'b001; use_rs1 = 1'b1; use_rd = 1'b1;
        imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      OP_STORE: begin
        ctrl_dec.mem_write = 1'b1; ctrl_dec.alu_src2 = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      OP_IMM: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src2 = 1'b1; ctrl_dec.alu_op = 2'b11;
        use_rs1 = 1'b1; use_rd = 1'b1;
        imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      OP_OP: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_op = 2'b10; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      default: ctrl_dec.illegal = 1'b1;
    endcase
    bad_idx = (use_rs1 & idx_hi(i_inst[19:15])) | (use_rs2 & idx_hi(i_inst[24:20])) |
              (use_rd & idx_hi(i_inst[11:7]));
    if (bad_idx) begin
      ctrl_dec.illegal   = 1'b1;
      ctrl_dec.reg_write = 1'b0;
    end
  end

  // Register-file write port; x0 is never written so it always reads zero.
  always_comb begin
    rf_d = rf_q;
    if (i_wb_en && (i_wb_addr != '0)) rf_d[i_wb_addr] = i_wb_data;
  end

  // Load-use hazard: a load in ID/EX whose rd feeds the offered instruction.
  always_comb begin
    haz = valid_q & ctrl_q.mem_read & (rd_q != '0) & i_valid &
          ((rd_q == rs1) | ((rd_q == rs2) & use_rs2));
    ready = !i_flush & !haz & (!valid_q | i_ready);
  end

  // ID/EX next state: flush > advance > drain/bubble > hold.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_valid && ready) begin
      valid_d = 1'b1;
      pc_d    = i_pc;
      imm_d   = XLEN'($signed(imm32));
      rd_d    = rd;
      ctrl_d  = ctrl_dec;
`ifdef ID_WB_BYPASS_EN
      rs1_data_d = rf_d[rs1];
      rs2_data_d = rf_d[rs2];
`else
      rs1_data_d = rf_q[rs1];
      rs2_data_d = rf_q[rs2];
`endif
    end else if (i_ready) begin
      // Covers both the load-use bubble and a plain drain with nothing offered.
      valid_d = 1'b0;
    end
  end

  // State registers: ID/EX boundary and register file.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rf_q       <= rf_d;
    end
  end

  assign o_ready    = ready;
  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_imm      = imm_q;
  assign o_rd       = rd_q;
  assign o_ctrl     = ctrl_q;
  assign o_rs1_data = rs1_data_q;
  assign o_rs2_data = rs2_data_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a 32-register instance for the pipeline
// behaviour and a 16-register instance for out-of-range register indices.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready_in, flush;
  logic [31:0] inst, pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        a_ready, a_valid;
  logic [31:0] a_pc, a_rs1, a_rs2, a_imm;
  logic [4:0]  a_rd;
  logic [13:0] a_ctrl;

  logic [31:0] b_inst;
  logic        b_wb_en;
  logic [3:0]  b_wb_addr;
  logic [31:0] b_wb_data;
  logic        b_ready, b_valid;
  logic [31:0] b_pc, b_rs1, b_rs2, b_imm;
  logic [3:0]  b_rd;
  logic [13:0] b_ctrl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NUM_REGS(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(a_ready), .i_inst(inst), .i_pc(pc),
    .i_flush(flush), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_valid(a_valid), .i_ready(ready_in), .o_pc(a_pc), .o_rs1_data(a_rs1), .o_rs2_data(a_rs2),
    .o_imm(a_imm), .o_rd(a_rd), .o_ctrl(a_ctrl)
  );

  id_stage_pipe #(.XLEN(32), .NUM_REGS(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(b_ready), .i_inst(b_inst), .i_pc(pc),
    .i_flush(flush), .i_wb_en(b_wb_en), .i_wb_addr(b_wb_addr), .i_wb_data(b_wb_data),
    .o_valid(b_valid), .i_ready(ready_in), .o_pc(b_pc), .o_rs1_data(b_rs1), .o_rs2_data(b_rs2),
    .o_imm(b_imm), .o_rd(b_rd), .o_ctrl(b_ctrl)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; ready_in = 1'b1; flush = 1'b0; inst = '0; pc = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    b_inst = '0; b_wb_en = 1'b0; b_wb_addr = '0; b_wb_data = '0;
    #12;
    chk_eq("rst_valid", 32'(a_valid), 32'd0);
    chk_eq("rst_pc", a_pc, 32'd0);
    chk_eq("rst_imm", a_imm, 32'd0);
    chk_eq("rst_ctrl", 32'(a_ctrl), 32'd0);
    chk_eq("rst_rd", 32'(a_rd), 32'd0);
    rst_n = 1'b1;
    tick();

    // addi x5,x0,7 with x1 <= 0x11 written back in the same cycle
    valid = 1'b1; inst = 32'h00700293; pc = 32'h100;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
    #1 chk_eq("addi_ready", 32'(a_ready), 32'd1);
    tick();
    wb_en = 1'b0;
    chk_eq("addi_valid", 32'(a_valid), 32'd1);
    chk_eq("addi_imm", a_imm, 32'd7);
    chk_eq("addi_rd", 32'(a_rd), 32'd5);
    chk_eq("addi_ctrl", 32'(a_ctrl), 32'h170);
    chk_eq("addi_rs1", a_rs1, 32'd0);
    chk_eq("addi_pc", a_pc, 32'h100);

    // lw x6,0(x5) then add x7,x6,x1 -> one stall cycle and one bubble
    inst = 32'h0002A303; pc = 32'h104;
    tick();
    chk_eq("lw_ctrl", 32'(a_ctrl), 32'h542);
    chk_eq("lw_rd", 32'(a_rd), 32'd6);
    inst = 32'h001303B3; pc = 32'h108;
    #1 chk_eq("luse_ready", 32'(a_ready), 32'd0);
    tick();
    chk_eq("luse_bubble", 32'(a_valid), 32'd0);
    chk_eq("luse_ready2", 32'(a_ready), 32'd1);
    tick();
    chk_eq("add_valid", 32'(a_valid), 32'd1);
    chk_eq("add_rd", 32'(a_rd), 32'd7);
    chk_eq("add_pc", a_pc, 32'h108);
    chk_eq("add_rs2", a_rs2, 32'h11);
    chk_eq("add_ctrl", 32'(a_ctrl), 32'h120);

    // EX stalled for 4 cycles while addi x8,x0,-1 is offered
    ready_in = 1'b0; inst = 32'hFFF00413; pc = 32'h10C;
    #1 chk_eq("stall_ready", 32'(a_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq("hold_ready", 32'(a_ready), 32'd0);
      chk_eq("hold_valid", 32'(a_valid), 32'd1);
      chk_eq("hold_pc", a_pc, 32'h108);
      chk_eq("hold_rd", 32'(a_rd), 32'd7);
      chk_eq("hold_rs1", a_rs1, 32'd0);
      chk_eq("hold_rs2", a_rs2, 32'h11);
      chk_eq("hold_imm", a_imm, 32'd0);
      chk_eq("hold_ctrl", 32'(a_ctrl), 32'h120);
    end
    ready_in = 1'b1;
    #1 chk_eq("unstall_ready", 32'(a_ready), 32'd1);
    tick();
    chk_eq("neg_imm", a_imm, 32'hFFFFFFFF);
    chk_eq("neg_rd", 32'(a_rd), 32'd8);
    chk_eq("neg_pc", a_pc, 32'h10C);

    // flush while addi x9,x0,5 is offered
    flush = 1'b1; inst = 32'h00500493; pc = 32'h110;
    #1 chk_eq("flush_ready", 32'(a_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk_eq("flush_valid", 32'(a_valid), 32'd0);
    chk_eq("flush_nocap_rd", 32'(a_rd), 32'd8);
    chk_eq("flush_nocap_pc", a_pc, 32'h10C);

    // addi x10,x3,0 read in the cycle x3 <= 0xDEADBEEF is written back
    inst = 32'h00018513; pc = 32'h114;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0;
`ifdef ID_WB_BYPASS_EN
    chk_eq("wb_same_cycle", a_rs1, 32'hDEADBEEF);
`else
    chk_eq("wb_same_cycle", a_rs1, 32'd0);
`endif
    chk_eq("wb_same_valid", 32'(a_valid), 32'd1);
    pc = 32'h118;
    tick();
    chk_eq("wb_later", a_rs1, 32'hDEADBEEF);

    // write to x0 is ignored, both same-cycle and afterwards
    inst = 32'h00000593; pc = 32'h11C;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    tick();
    wb_en = 1'b0;
    chk_eq("x0_same_cycle", a_rs1, 32'd0);
    pc = 32'h120;
    tick();
    chk_eq("x0_later", a_rs1, 32'd0);

    // lw x6 then addi x13,x0,6: rs2 field matches rd but I-type ignores rs2
    inst = 32'h0002A303; pc = 32'h124;
    tick();
    inst = 32'h00600693; pc = 32'h128;
    #1 chk_eq("rs2_unused_ready", 32'(a_ready), 32'd1);
    tick();
    chk_eq("rs2_unused_rd", 32'(a_rd), 32'd13);

    // lw x0 then addi x12,x0,1: load to x0 never stalls
    inst = 32'h0000A003; pc = 32'h12C;
    tick();
    inst = 32'h00100613; pc = 32'h130;
    #1 chk_eq("ld_x0_ready", 32'(a_ready), 32'd1);
    tick();
    chk_eq("ld_x0_imm", a_imm, 32'd1);

    // unknown opcode
    inst = 32'hFFFFFFFF; pc = 32'h134;
    tick();
    chk_eq("illegal_ctrl", 32'(a_ctrl), 32'h001);
    chk_eq("illegal_valid", 32'(a_valid), 32'd1);

    // lw x6 then sw x6,0(x2): rs2 dependency stalls
    inst = 32'h0002A303; pc = 32'h138;
    tick();
    inst = 32'h00612023; pc = 32'h13C;
    #1 chk_eq("sw_luse_ready", 32'(a_ready), 32'd0);
    tick();
    chk_eq("sw_bubble", 32'(a_valid), 32'd0);
    tick();
    chk_eq("sw_ctrl", 32'(a_ctrl), 32'h240);
    chk_eq("sw_pc", a_pc, 32'h13C);

    // nothing offered: ID/EX drains
    valid = 1'b0;
    tick();
    chk_eq("drain_valid", 32'(a_valid), 32'd0);

    // 16-register instance: x4 <= 0x44, then addi x20,x0,1 must be illegal
    b_wb_en = 1'b1; b_wb_addr = 4'd4; b_wb_data = 32'h44;
    tick();
    b_wb_en = 1'b0;
    valid = 1'b1; b_inst = 32'h00100A13; pc = 32'h200; inst = 32'h00000013;
    tick();
    chk_eq("r16_valid", 32'(b_valid), 32'd1);
    chk_eq("r16_illegal", 32'(b_ctrl[0]), 32'd1);
    chk_eq("r16_regwrite", 32'(b_ctrl[8]), 32'd0);
    chk_eq("r16_ctrl", 32'(b_ctrl), 32'h071);
    b_inst = 32'h00020093; pc = 32'h204;
    tick();
    chk_eq("r16_x4_intact", b_rs1, 32'h44);
    chk_eq("r16_legal", 32'(b_ctrl[0]), 32'd0);

    // reset mid-operation clears the in-flight instruction asynchronously
    inst = 32'h00700293; pc = 32'h300;
    tick();
    chk_eq("pre_rst_valid", 32'(a_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_valid", 32'(a_valid), 32'd0);
    chk_eq("mid_rst_pc", a_pc, 32'd0);
    chk_eq("mid_rst_ctrl", 32'(a_ctrl), 32'd0);
    valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
